// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: commit-trace capture for the dual-issue in-order core.
// Packs up to LANES retired (pc, inst) pairs per cycle into a DEPTH-entry
// circular buffer, drained through a first-word-fall-through ready/valid port.
// WRAP=0 stops on full and flags overflow; WRAP=1 overwrites the oldest entries.
// Optional feature macro: RISCV_TRACE_TRIGGER_EN adds a PC-match trigger that
// freezes capture once the matching instruction has been stored.
module riscv_trace_buffer #(
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [LANES-1:0]           valid_i,
    input  logic [32*LANES-1:0]        pc_i,
    input  logic [32*LANES-1:0]        inst_i,
    input  logic                       enable_i,
    input  logic                       clear_i,
    output logic                       rd_valid_o,
    output logic [31:0]                rd_pc_o,
    output logic [31:0]                rd_inst_o,
    input  logic                       rd_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [31:0]                retired_o
`ifdef RISCV_TRACE_TRIGGER_EN
    ,
    input  logic                       trig_en_i,
    input  logic [31:0]                trig_pc_i,
    output logic                       triggered_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = CW + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, FROZEN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       retired_q, retired_d;

    logic [31:0]       mem_pc   [DEPTH];
    logic [31:0]       mem_inst [DEPTH];

    logic              capture;
    logic [LANES-1:0]  lane_en;
    logic [CW-1:0]     rank [LANES];
    logic [CW-1:0]     n_push;
    logic [CW-1:0]     room;
    logic [CW-1:0]     stored;
    logic [CW-1:0]     drop;
    logic [TW-1:0]     total;
    logic              lost;
    logic              pop;
    logic              trig_hit;

`ifdef RISCV_TRACE_TRIGGER_EN
    logic              triggered_q, triggered_d;
`endif

    assign capture = (state_q == CAPTURE);

    // Lanes eligible for capture; a trigger match masks off every higher lane
    always_comb begin
        lane_en  = '0;
        trig_hit = 1'b0;
        if (capture) begin
            lane_en = valid_i;
`ifdef RISCV_TRACE_TRIGGER_EN
            if (trig_en_i) begin
                for (int i = 0; i < LANES; i++) begin
                    if (trig_hit) begin
                        lane_en[i] = 1'b0;
                    end else if (valid_i[i] && (pc_i[32*i +: 32] == trig_pc_i)) begin
                        trig_hit = 1'b1;
                    end
                end
            end
`endif
        end
    end

    // Packed slot offset of each lane: number of enabled lanes below it
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            rank[i] = acc;
            if (lane_en[i]) begin
                acc = acc + CW'(1);
            end
        end
        n_push = acc;
    end

    // Space accounting, pointer/counter updates and state transitions
    always_comb begin
        pop        = rd_ready_i && (count_q != '0);
        room       = CW'(DEPTH) - count_q;
        total      = TW'(count_q) - TW'(pop) + TW'(n_push);
        stored     = n_push;
        drop       = '0;
        lost       = 1'b0;
        if (WRAP == 0) begin
            if (n_push > room) begin
                stored = room;
                lost   = 1'b1;
            end
        end else begin
            if (total > TW'(DEPTH)) begin
                drop = CW'(total - TW'(DEPTH));
                lost = 1'b1;
            end
        end

        wr_ptr_d   = wr_ptr_q + AW'(stored);
        rd_ptr_d   = rd_ptr_q + AW'(pop) + AW'(drop);
        count_d    = count_q + stored - CW'(pop) - drop;
        overflow_d = overflow_q | lost;
        retired_d  = capture ? (retired_q + 32'(n_push)) : retired_q;
`ifdef RISCV_TRACE_TRIGGER_EN
        triggered_d = triggered_q | trig_hit;
`endif

        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = CAPTURE;
            CAPTURE: begin
                if (trig_hit)       state_d = FROZEN;
                else if (!enable_i) state_d = IDLE;
            end
            FROZEN:  state_d = FROZEN;
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            retired_d  = '0;
`ifdef RISCV_TRACE_TRIGGER_EN
            triggered_d = 1'b0;
`endif
        end
    end

    // Control state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            retired_q  <= '0;
`ifdef RISCV_TRACE_TRIGGER_EN
            triggered_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            retired_q  <= retired_d;
`ifdef RISCV_TRACE_TRIGGER_EN
            triggered_q <= triggered_d;
`endif
        end
    end

    // Trace storage: each kept lane lands at wr_ptr + its packed rank
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i] && (rank[i] < stored) && !clear_i) begin
                mem_pc[wr_ptr_q + AW'(rank[i])]   <= pc_i[32*i +: 32];
                mem_inst[wr_ptr_q + AW'(rank[i])] <= inst_i[32*i +: 32];
            end
        end
    end

    // Head is read combinationally; forced to zero while empty so the
    // unreset storage never shows on the port
    assign rd_valid_o = (count_q != '0);
    assign rd_pc_o    = rd_valid_o ? mem_pc[rd_ptr_q]   : '0;
    assign rd_inst_o  = rd_valid_o ? mem_inst[rd_ptr_q] : '0;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign retired_o  = retired_q;
`ifdef RISCV_TRACE_TRIGGER_EN
    assign triggered_o = triggered_q;
`endif

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: two DEPTH=4, LANES=2 instances (WRAP=0 and
// WRAP=1) share stimulus; a vector table plus hand-written corner sequences.
module tb_riscv_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid = '0;
    logic [63:0] pc = '0;
    logic [63:0] inst = '0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;

    logic        a_rd_valid, b_rd_valid;
    logic [31:0] a_pc, b_pc, a_inst, b_inst;
    logic [2:0]  a_count, b_count;
    logic        a_ovf, b_ovf;
    logic [31:0] a_ret, b_ret;
`ifdef RISCV_TRACE_TRIGGER_EN
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        a_trig, b_trig;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    riscv_trace_buffer #(.LANES(2), .DEPTH(4), .WRAP(0)) u_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .inst_i(inst),
        .enable_i(enable), .clear_i(clear), .rd_valid_o(a_rd_valid),
        .rd_pc_o(a_pc), .rd_inst_o(a_inst), .rd_ready_i(ready),
        .count_o(a_count), .overflow_o(a_ovf), .retired_o(a_ret)
`ifdef RISCV_TRACE_TRIGGER_EN
        , .trig_en_i(trig_en), .trig_pc_i(trig_pc), .triggered_o(a_trig)
`endif
    );

    riscv_trace_buffer #(.LANES(2), .DEPTH(4), .WRAP(1)) u_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .inst_i(inst),
        .enable_i(enable), .clear_i(clear), .rd_valid_o(b_rd_valid),
        .rd_pc_o(b_pc), .rd_inst_o(b_inst), .rd_ready_i(ready),
        .count_o(b_count), .overflow_o(b_ovf), .retired_o(b_ret)
`ifdef RISCV_TRACE_TRIGGER_EN
        , .trig_en_i(trig_en), .trig_pc_i(trig_pc), .triggered_o(b_trig)
`endif
    );

    typedef struct {
        logic        clr;
        logic [1:0]  vld;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        rdy;
        int          a_cnt;
        logic [31:0] a_head;
        logic        a_ovf;
        int          b_cnt;
        logic [31:0] b_head;
        logic        b_ovf;
        int          ret;
    } vec_t;

    vec_t vecs [64];
    int   nv = 0;

    task automatic add(input logic clr, input logic [1:0] vld,
                       input logic [31:0] pc0, input logic [31:0] pc1, input logic rdy,
                       input int ac, input logic [31:0] ah, input logic ao,
                       input int bc, input logic [31:0] bh, input logic bo, input int ret);
        vecs[nv] = '{clr, vld, pc0, pc1, rdy, ac, ah, ao, bc, bh, bo, ret};
        nv++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic [1:0] vld,
                         input logic [31:0] pc0, input logic [31:0] pc1, input logic rdy);
        clear = clr;
        valid = vld;
        pc    = {pc1, pc0};
        inst  = {~pc1, ~pc0};
        ready = rdy;
    endtask

    task automatic step(input int idx);
        vec_t v;
        v = vecs[idx];
        drive(v.clr, v.vld, v.pc0, v.pc1, v.rdy);
        @(posedge clk);
        #1;
        $display("[TB] v%0d clr=%0b vld=%b pc0=%h pc1=%h rdy=%0b -> A cnt=%0d head=%h ovf=%0b | B cnt=%0d head=%h ovf=%0b | ret=%0d",
                 idx, v.clr, v.vld, v.pc0, v.pc1, v.rdy, a_count, a_pc, a_ovf, b_count, b_pc, b_ovf, a_ret);
        chk($sformatf("v%0d a_count", idx), 32'(a_count), 32'(v.a_cnt));
        chk($sformatf("v%0d b_count", idx), 32'(b_count), 32'(v.b_cnt));
        chk($sformatf("v%0d a_rd_valid", idx), 32'(a_rd_valid), 32'(v.a_cnt != 0));
        chk($sformatf("v%0d b_rd_valid", idx), 32'(b_rd_valid), 32'(v.b_cnt != 0));
        chk($sformatf("v%0d a_overflow", idx), 32'(a_ovf), 32'(v.a_ovf));
        chk($sformatf("v%0d b_overflow", idx), 32'(b_ovf), 32'(v.b_ovf));
        chk($sformatf("v%0d a_retired", idx), a_ret, 32'(v.ret));
        chk($sformatf("v%0d b_retired", idx), b_ret, 32'(v.ret));
        if (v.a_cnt != 0) begin
            chk($sformatf("v%0d a_head_pc", idx), a_pc, v.a_head);
            chk($sformatf("v%0d a_head_inst", idx), a_inst, ~v.a_head);
        end
        if (v.b_cnt != 0) begin
            chk($sformatf("v%0d b_head_pc", idx), b_pc, v.b_head);
            chk($sformatf("v%0d b_head_inst", idx), b_inst, ~v.b_head);
        end
    endtask

    initial begin
        // clr vld pc0 pc1 rdy | A cnt head ovf | B cnt head ovf | retired
        add(0, 2'b11, 32'h900, 32'h904, 0, 0, 0, 0, 0, 0, 0, 0);          // IDLE: ignored
        add(0, 2'b11, 32'h100, 32'h104, 0, 2, 32'h100, 0, 2, 32'h100, 0, 2);
        add(0, 2'b00, 0, 0, 1, 1, 32'h104, 0, 1, 32'h104, 0, 2);
        add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2);
        add(0, 2'b10, 32'hdead, 32'h200, 0, 1, 32'h200, 0, 1, 32'h200, 0, 3); // no gap
        add(1, 2'b11, 32'h500, 32'h504, 1, 0, 0, 0, 0, 0, 0, 0);          // clear wins
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                      // IDLE -> CAPTURE
        add(0, 2'b11, 32'h0, 32'h4, 0, 2, 32'h0, 0, 2, 32'h0, 0, 2);
        add(0, 2'b11, 32'h8, 32'hc, 0, 4, 32'h0, 0, 4, 32'h0, 0, 4);
        add(0, 2'b11, 32'h10, 32'h14, 0, 4, 32'h0, 1, 4, 32'h8, 1, 6);    // full
        add(0, 2'b01, 32'h18, 0, 1, 3, 32'h4, 1, 4, 32'hc, 1, 7);         // pop+push at full
        add(0, 2'b00, 0, 0, 1, 2, 32'h8, 1, 3, 32'h10, 1, 7);
        add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            add(0, 2'b01, 32'h1000 + 32'(4 * k), 0, 1,
                1, 32'h1000 + 32'(4 * k), 0, 1, 32'h1000 + 32'(4 * k), 0, k + 1);
        end
        add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 12);

        // Reset state
        @(posedge clk);
        #1;
        chk("reset a_count", 32'(a_count), 0);
        chk("reset b_count", 32'(b_count), 0);
        chk("reset a_rd_valid", 32'(a_rd_valid), 0);
        chk("reset a_overflow", 32'(a_ovf), 0);
        chk("reset a_retired", a_ret, 0);
        chk("reset a_rd_pc", a_pc, 0);
        chk("reset a_rd_inst", a_inst, 0);
        rst    = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < nv; i++) begin
            step(i);
        end

        // Asynchronous reset mid-operation discards contents at once
        drive(0, 2'b11, 32'h700, 32'h704, 0);
        @(posedge clk);
        #1;
        chk("pre-reset a_count", 32'(a_count), 2);
        drive(0, 2'b00, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] async reset -> A cnt=%0d B cnt=%0d ret=%0d", a_count, b_count, a_ret);
        chk("async-reset a_count", 32'(a_count), 0);
        chk("async-reset b_count", 32'(b_count), 0);
        chk("async-reset b_rd_valid", 32'(b_rd_valid), 0);
        chk("async-reset a_retired", a_ret, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Dropping enable keeps stored entries readable and stops capture
        drive(0, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 2'b01, 32'h800, 0, 0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        drive(0, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 2'b11, 32'h810, 32'h814, 0);
        @(posedge clk);
        #1;
        $display("[TB] enable low -> A cnt=%0d head=%h ret=%0d", a_count, a_pc, a_ret);
        chk("enable-low a_count", 32'(a_count), 1);
        chk("enable-low a_head_pc", a_pc, 32'h800);
        chk("enable-low b_retired", b_ret, 1);
        enable = 1'b1;

`ifdef RISCV_TRACE_TRIGGER_EN
        // Trigger: store the matching lane and lower lanes, then freeze
        drive(1, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        trig_en = 1'b1;
        trig_pc = 32'h300;
        drive(0, 2'b11, 32'h300, 32'h304, 0);
        @(posedge clk);
        #1;
        $display("[TB] trigger hit -> A cnt=%0d head=%h trig=%0b ret=%0d", a_count, a_pc, a_trig, a_ret);
        chk("trig a_count", 32'(a_count), 1);
        chk("trig a_head_pc", a_pc, 32'h300);
        chk("trig a_triggered", 32'(a_trig), 1);
        chk("trig b_retired", b_ret, 1);
        drive(0, 2'b11, 32'h400, 32'h404, 0);
        @(posedge clk);
        #1;
        $display("[TB] frozen push -> A cnt=%0d ret=%0d", a_count, a_ret);
        chk("frozen a_count", 32'(a_count), 1);
        chk("frozen a_retired", a_ret, 1);
        drive(0, 2'b00, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("frozen pop a_count", 32'(a_count), 0);
        trig_en = 1'b0;
        drive(1, 2'b00, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("[TB] clear after trigger -> A cnt=%0d trig=%0b", a_count, a_trig);
        chk("clear b_triggered", 32'(b_trig), 0);
        drive(0, 2'b11, 32'h500, 32'h504, 0);
        @(posedge clk);
        #1;
        chk("post-clear idle a_count", 32'(a_count), 0);
        drive(0, 2'b11, 32'h600, 32'h604, 0);
        @(posedge clk);
        #1;
        chk("post-clear capture a_count", 32'(a_count), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
